minmaxf_pipelined: RTL

//   Elastic IEEE-754 floating-point minimum/maximum unit for dataflow circuits.

---
 rtl/minmaxf_pipelined.sv | 68 ++++++
 1 files changed

// File: rtl/minmaxf_pipelined.sv
// minmaxf_pipelined: elastic IEEE-754 min/max with NaN propagation and a bubble-collapsing pipeline
module minmaxf_pipelined #(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 23,
  parameter int LATENCY    = 1,
  parameter int IS_MAX     = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [EXP_WIDTH+FRAC_WIDTH:0]       lhs,
  input  logic                                lhs_valid,
  input  logic [EXP_WIDTH+FRAC_WIDTH:0]       rhs,
  input  logic                                rhs_valid,
  input  logic                                result_ready,
  output logic [EXP_WIDTH+FRAC_WIDTH:0]       result,
  output logic                                result_valid,
  output logic                                lhs_ready,
  output logic                                rhs_ready
);
  localparam int DATA_TYPE = 1 + EXP_WIDTH + FRAC_WIDTH;
  localparam logic [DATA_TYPE-1:0] QNAN = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(FRAC_WIDTH-1){1'b0}}};
  localparam logic [DATA_TYPE-1:0] MSB = {1'b1, {(DATA_TYPE-1){1'b0}}};
  if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
    $error("minmaxf_pipelined: LATENCY must be in 1..8");
  end
  logic [DATA_TYPE-1:0] d [LATENCY];
  logic [DATA_TYPE-1:0] d_in [LATENCY];
  logic [LATENCY-1:0] v, v_in, en;
  logic [DATA_TYPE-1:0] sel, lhs_key, rhs_key;
  logic lhs_nan, rhs_nan, lhs_wins, fire;
  // Order keys map the sign-magnitude encoding onto unsigned order, so -0 < +0.
  always_comb begin
    lhs_nan = (&lhs[DATA_TYPE-2 -: EXP_WIDTH]) & (|lhs[FRAC_WIDTH-1:0]);
    rhs_nan = (&rhs[DATA_TYPE-2 -: EXP_WIDTH]) & (|rhs[FRAC_WIDTH-1:0]);
    lhs_key = lhs[DATA_TYPE-1] ? ~lhs : lhs ^ MSB;
    rhs_key = rhs[DATA_TYPE-1] ? ~rhs : rhs ^ MSB;
    lhs_wins = (IS_MAX != 0) ? lhs_key >= rhs_key : lhs_key <= rhs_key;
    sel = (lhs_nan | rhs_nan) ? QNAN : lhs_wins ? lhs : rhs;
  end
  always_comb begin
    en[LATENCY-1] = !v[LATENCY-1] | result_ready;
    for (int k = LATENCY - 2; k >= 0; k--) en[k] = !v[k] | en[k+1];
  end
  assign fire      = lhs_valid & rhs_valid & en[0];
  assign lhs_ready = rhs_valid & en[0];
  assign rhs_ready = lhs_valid & en[0];
  always_comb begin
    v_in[0] = fire;
    d_in[0] = sel;
    for (int k = 1; k < LATENCY; k++) begin
      v_in[k] = v[k-1];
      d_in[k] = d[k-1];
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v <= '0;
      for (int k = 0; k < LATENCY; k++) d[k] <= '0;
    end else begin
      for (int k = 0; k < LATENCY; k++)
        if (en[k]) begin
          v[k] <= v_in[k];
          d[k] <= d_in[k];
        end
    end
  assign result       = d[LATENCY-1];
  assign result_valid = v[LATENCY-1];
endmodule
